obi_spi_master_mcs: RTL and testbench

//  OBI subordinate SPI master; merges data shift, chip-select and data/command control into one

---
 rtl/obi_spi_master_mcs.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_obi_spi_master_mcs.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_spi_master_mcs.sv
// ---------------------------------------------------------------------------
// obi_spi_master_mcs
//   OBI subordinate SPI master (TX only) with a TX FIFO of {dc, byte} entries,
//   NumCs active-low chip selects, a per-frame data/command bit, programmable
//   SCK divider, all four CPOL/CPHA modes and a level done interrupt.
//
// Ports
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   req_i/gnt_o         OBI request / grant (grant is req_i, combinational)
//   we_i, be_i, addr_i  OBI write enable, byte enables (ignored), address
//   wdata_i, aid_i      OBI write data and transaction id
//   rvalid_o, rdata_o   OBI response valid (one cycle after grant), read data
//   rid_o, err_o        OBI response id and error
//   sck_o, mosi_o       SPI clock and data out (MSB first)
//   cs_no               chip selects, active low
//   dc_o                data/command bit of the current frame
//   irq_o               done interrupt (done_pend & done_en, registered)
//
// Register map (addr_i[4:2])
//   0 CTRL   RW  [7:0] clkdiv, [8] cpol, [9] cpha, [10] en, [11] cs_hold,
//                [15:12] cs_sel
//   1 TXDATA WO  [8] dc, [7:0] byte (push); reads 0; push while full -> err
//   2 STATUS RO  [0] busy, [1] full, [2] empty, [15:8] level
//   3 IRQ    RW  [0] done_pend (write 1 to clear), [1] done_en
//   4..7         read 0, writes ignored, err
// ---------------------------------------------------------------------------
module obi_spi_master_mcs #(
    parameter int unsigned NumCs     = 2,
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned IdWidth   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    input  logic [IdWidth-1:0] aid_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic [IdWidth-1:0] rid_o,
    output logic               err_o,
    output logic               sck_o,
    output logic               mosi_o,
    output logic [NumCs-1:0]   cs_no,
    output logic               dc_o,
    output logic               irq_o
);

    localparam int unsigned AW = $clog2(FifoDepth);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [2:0] reg_sel;
    logic       bus_wr;
    logic       bus_rd;

    assign reg_sel = addr_i[4:2];
    assign bus_wr  = req_i & we_i;
    assign bus_rd  = req_i & ~we_i;
    assign gnt_o   = req_i;

    logic unused_bits;
    assign unused_bits = ^{be_i, addr_i[31:5], addr_i[1:0], wdata_i[31:16]};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0]        ctrl_q;
    logic               done_pend_q;
    logic               done_en_q;
    logic               irq_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;
    logic [IdWidth-1:0] rid_q;
    logic               err_q;

    logic [7:0] ctrl_div;
    logic       ctrl_cpol;
    logic       ctrl_cpha;
    logic       ctrl_en;
    logic       ctrl_hold;
    logic [3:0] ctrl_sel;

    assign ctrl_div  = ctrl_q[7:0];
    assign ctrl_cpol = ctrl_q[8];
    assign ctrl_cpha = ctrl_q[9];
    assign ctrl_en   = ctrl_q[10];
    assign ctrl_hold = ctrl_q[11];
    assign ctrl_sel  = ctrl_q[15:12];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [8:0]    mem_q [FifoDepth];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic [8:0]    fifo_head;
    logic          push;
    logic          pop;

    assign fifo_full  = (count_q == CW'(FifoDepth));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = mem_q[rptr_q];
    // Full is judged on the registered level, so a pop in the same cycle
    // does not make room for a push.
    assign push       = bus_wr & (reg_sel == 3'd1) & ~fifo_full;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata_i[8:0];
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Shift engine
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [7:0]       div_cnt_q;
    logic [3:0]       edge_cnt_q;
    logic [7:0]       div_q;
    logic             cpha_q;
    logic [3:0]       sel_q;
    logic [7:0]       sr_q;
    logic             sck_q;
    logic             mosi_q;
    logic [NumCs-1:0] cs_q;
    logic             dc_q;

    logic             div_done;
    logic             shift_now;
    logic             done_set;
    logic [NumCs-1:0] cs_dec;

    assign div_done = (div_cnt_q == div_q);

    // Edge numbering is edge_cnt_q+1. MOSI starts on bit 7, so the first
    // advance in either phase is skipped: CPHA=0 advances on edges 2..14,
    // CPHA=1 advances on edges 3..15.
    assign shift_now = cpha_q ? (~edge_cnt_q[0] & (edge_cnt_q != 4'd0))
                              : ( edge_cnt_q[0] & (edge_cnt_q != 4'd15));

    // Chaining into the next frame requires the selected CS to be unchanged.
    assign pop = ctrl_en & ~fifo_empty &
                 ((state_q == S_IDLE) |
                  ((state_q == S_HOLD) & div_done & ctrl_hold & (ctrl_sel == sel_q)));

    assign done_set = (state_q == S_GAP) & div_done & fifo_empty;

    // Out-of-range cs_sel matches no bit, leaving all selects high.
    always_comb begin
        cs_dec = '1;
        for (int unsigned i = 0; i < NumCs; i++) begin
            if (32'(ctrl_sel) == i) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            div_q      <= '0;
            cpha_q     <= 1'b0;
            sel_q      <= '0;
            sr_q       <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= '1;
            dc_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sck_q <= ctrl_cpol;
                    if (pop) begin
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (div_done) begin
                        div_cnt_q <= '0;
                        state_q   <= S_SHIFT;
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (div_done) begin
                        div_cnt_q  <= '0;
                        sck_q      <= ~sck_q;
                        edge_cnt_q <= edge_cnt_q + 4'd1;
                        if (shift_now) begin
                            sr_q   <= {sr_q[6:0], 1'b0};
                            mosi_q <= sr_q[6];
                        end
                        if (edge_cnt_q == 4'd15) begin
                            state_q <= S_HOLD;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (div_done) begin
                        div_cnt_q <= '0;
                        if (pop) begin
                            state_q <= S_SETUP;
                        end else begin
                            cs_q    <= '1;
                            state_q <= S_GAP;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (div_done) begin
                        div_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Frame load overrides the per-state updates above; it latches
            // the CTRL fields so later CTRL writes only affect the next pop.
            if (pop) begin
                div_q      <= ctrl_div;
                cpha_q     <= ctrl_cpha;
                sel_q      <= ctrl_sel;
                sck_q      <= ctrl_cpol;
                dc_q       <= fifo_head[8];
                sr_q       <= fifo_head[7:0];
                mosi_q     <= fifo_head[7];
                cs_q       <= cs_dec;
                div_cnt_q  <= '0;
                edge_cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file and OBI response
    // ------------------------------------------------------------------
    logic [31:0] rd_data;
    logic        resp_err;
    logic [31:0] status;

    assign status = {16'h0, 8'(count_q), 5'h0, fifo_empty, fifo_full, (state_q != S_IDLE)};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0:    rd_data = {16'h0, ctrl_q};
            3'd2:    rd_data = status;
            3'd3:    rd_data = {30'h0, done_en_q, done_pend_q};
            default: rd_data = '0;
        endcase
    end

    assign resp_err = reg_sel[2] | (bus_wr & (reg_sel == 3'd1) & fifo_full);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q      <= '0;
            done_pend_q <= 1'b0;
            done_en_q   <= 1'b0;
            irq_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rid_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            if (bus_wr && reg_sel == 3'd0) begin
                ctrl_q <= wdata_i[15:0];
            end
            if (bus_wr && reg_sel == 3'd3) begin
                done_en_q <= wdata_i[1];
            end
            // A completion landing on the same cycle as the clear wins.
            done_pend_q <= done_set |
                           (done_pend_q & ~(bus_wr & (reg_sel == 3'd3) & wdata_i[0]));
            irq_q       <= done_pend_q & done_en_q;

            rvalid_q <= req_i;
            rdata_q  <= bus_rd ? rd_data : '0;
            err_q    <= req_i & resp_err;
            if (req_i) begin
                rid_q <= aid_i;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rid_o    = rid_q;
    assign err_o    = err_q;
    assign sck_o    = sck_q;
    assign mosi_o   = mosi_q;
    assign cs_no    = cs_q;
    assign dc_o     = dc_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_obi_spi_master_mcs.sv
// ---------------------------------------------------------------------------
// tb_obi_spi_master_mcs
//   Directed bench for obi_spi_master_mcs (NumCs=2, FifoDepth=8, IdWidth=1).
//   Inputs change on the falling clock edge, outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_obi_spi_master_mcs;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [0:0]  aid_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [0:0]  rid_o;
    logic        err_o;
    logic        sck_o;
    logic        mosi_o;
    logic [1:0]  cs_no;
    logic        dc_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    obi_spi_master_mcs #(
        .NumCs    (2),
        .FifoDepth(8),
        .IdWidth  (1)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .aid_i   (aid_i),
        .gnt_o   (gnt_o),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .rid_o   (rid_o),
        .err_o   (err_o),
        .sck_o   (sck_o),
        .mosi_o  (mosi_o),
        .cs_no   (cs_no),
        .dc_o    (dc_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the response cycle.
    task automatic obi_write(input logic [31:0] a, input logic [31:0] d, output logic e);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
        e = err_o;
    endtask

    task automatic obi_read(input logic [31:0] a, output logic [31:0] d, output logic e,
                            output logic v);
        req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        d = rdata_o; e = err_o; v = rvalid_o;
    endtask

    // Waits for CS to go low, then collects MOSI on every rising SCK until CS
    // returns high. Returns on the first falling clock edge with CS high.
    task automatic capture(output logic [31:0] data, output int nbits, output int cs_cyc,
                           output logic dc, output logic [1:0] cs_seen, output logic tmo);
        int   guard;
        logic sck_prev;
        data = '0; nbits = 0; cs_cyc = 0; dc = 1'b0; cs_seen = 2'b11; tmo = 1'b0; guard = 0;
        while (cs_no === 2'b11 && guard < 2000) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 2000) begin
            tmo = 1'b1;
        end else begin
            dc       = dc_o;
            cs_seen  = cs_no;
            sck_prev = sck_o;
            while (cs_no !== 2'b11 && guard < 4000) begin
                cs_cyc++;
                if (!sck_prev && sck_o) begin
                    data = {data[30:0], mosi_o};
                    nbits++;
                end
                sck_prev = sck_o;
                @(negedge clk_i);
                guard++;
            end
            if (guard >= 4000) tmo = 1'b1;
        end
    endtask

    task automatic count_gap(output int gap);
        gap = 0;
        while (cs_no === 2'b11 && gap < 1000) begin
            gap++;
            @(negedge clk_i);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    logic        vl;
    logic [31:0] cap;
    int          nb;
    int          cc;
    int          gap;
    logic        cdc;
    logic [1:0]  csq;
    logic        tmo;

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'hF;
        addr_i = '0; wdata_i = '0; aid_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Reset values
        check("rst_cs_no", 32'(cs_no), 32'h3);
        check("rst_sck", 32'(sck_o), 32'h0);
        check("rst_mosi", 32'(mosi_o), 32'h0);
        check("rst_dc", 32'(dc_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        req_i = 1'b1; #1;
        check("gnt_follows_req", 32'(gnt_o), 32'h1);
        req_i = 1'b0; #1;
        check("gnt_low", 32'(gnt_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        obi_read(32'h08, rd, er, vl);
        check("rst_status", rd, 32'h0000_0004);
        check("rd_rvalid", 32'(vl), 32'h1);
        check("rd_err", 32'(er), 32'h0);

        // Mode 0, clkdiv 0, cs0, byte 0xA5 with dc=0
        obi_write(32'h00, 32'h0000_0400, er);
        obi_write(32'h04, 32'h0000_00A5, er);
        check("push_a5_err", 32'(er), 32'h0);
        capture(cap, nb, cc, cdc, csq, tmo);
        check("m0_timeout", 32'(tmo), 32'h0);
        check("m0_data", cap, 32'h0000_00A5);
        check("m0_bits", 32'(nb), 32'd8);
        check("m0_cs_cycles", 32'(cc), 32'd18);
        check("m0_cs_sel", 32'(csq), 32'h2);
        check("m0_dc", 32'(cdc), 32'h0);
        repeat (3) @(negedge clk_i);
        obi_read(32'h0C, rd, er, vl);
        check("m0_done_pend", rd, 32'h0000_0001);
        obi_read(32'h08, rd, er, vl);
        check("m0_status_idle", rd, 32'h0000_0004);
        check("m0_irq_disabled", 32'(irq_o), 32'h0);

        // Mode 3, clkdiv 3 (H=4), byte 0x3C with dc=1
        obi_write(32'h0C, 32'h0000_0001, er);
        obi_write(32'h00, 32'h0000_0703, er);
        @(negedge clk_i);
        check("m3_sck_idle", 32'(sck_o), 32'h1);
        obi_write(32'h04, 32'h0000_013C, er);
        capture(cap, nb, cc, cdc, csq, tmo);
        check("m3_timeout", 32'(tmo), 32'h0);
        check("m3_data", cap, 32'h0000_003C);
        check("m3_bits", 32'(nb), 32'd8);
        check("m3_cs_cycles", 32'(cc), 32'd72);
        check("m3_dc", 32'(cdc), 32'h1);
        check("m3_sck_after", 32'(sck_o), 32'h1);

        // cs_hold: three frames under one continuous CS
        obi_write(32'h00, 32'h0000_0800, er);
        obi_write(32'h04, 32'h0000_0011, er);
        obi_write(32'h04, 32'h0000_0022, er);
        obi_write(32'h04, 32'h0000_0033, er);
        obi_write(32'h00, 32'h0000_0C00, er);
        capture(cap, nb, cc, cdc, csq, tmo);
        check("hold_timeout", 32'(tmo), 32'h0);
        check("hold_data", cap, 32'h0011_2233);
        check("hold_bits", 32'(nb), 32'd24);
        check("hold_cs_cycles", 32'(cc), 32'd54);

        // cs_hold=0: CS released between frames
        obi_write(32'h00, 32'h0000_0000, er);
        obi_write(32'h04, 32'h0000_0044, er);
        obi_write(32'h04, 32'h0000_0055, er);
        obi_write(32'h04, 32'h0000_0066, er);
        obi_write(32'h00, 32'h0000_0400, er);
        capture(cap, nb, cc, cdc, csq, tmo);
        check("nohold_f1_data", cap, 32'h0000_0044);
        check("nohold_f1_cs", 32'(cc), 32'd18);
        count_gap(gap);
        check("nohold_gap1", 32'(gap >= 1 && gap <= 3), 32'h1);
        capture(cap, nb, cc, cdc, csq, tmo);
        check("nohold_f2_data", cap, 32'h0000_0055);
        check("nohold_f2_cs", 32'(cc), 32'd18);
        count_gap(gap);
        check("nohold_gap2", 32'(gap >= 1 && gap <= 3), 32'h1);
        capture(cap, nb, cc, cdc, csq, tmo);
        check("nohold_f3_data", cap, 32'h0000_0066);
        check("nohold_f3_timeout", 32'(tmo), 32'h0);

        // Done interrupt
        repeat (3) @(negedge clk_i);
        obi_write(32'h0C, 32'h0000_0003, er);
        repeat (2) @(negedge clk_i);
        check("irq_cleared_en", 32'(irq_o), 32'h0);
        obi_write(32'h04, 32'h0000_00FF, er);
        capture(cap, nb, cc, cdc, csq, tmo);
        check("irq_frame_data", cap, 32'h0000_00FF);
        repeat (3) @(negedge clk_i);
        check("irq_set", 32'(irq_o), 32'h1);
        obi_write(32'h0C, 32'h0000_0003, er);
        repeat (2) @(negedge clk_i);
        check("irq_w1c", 32'(irq_o), 32'h0);
        // Clear lands on the GAP->IDLE edge, 20 edges after the push edge.
        obi_write(32'h04, 32'h0000_00FF, er);
        repeat (19) @(negedge clk_i);
        obi_write(32'h0C, 32'h0000_0003, er);
        repeat (3) @(negedge clk_i);
        check("irq_set_wins", 32'(irq_o), 32'h1);
        obi_read(32'h0C, rd, er, vl);
        check("irq_reg_set_wins", rd, 32'h0000_0003);

        // FIFO overflow and bad addresses
        obi_write(32'h00, 32'h0000_0000, er);
        for (int i = 0; i < 9; i++) begin
            obi_write(32'h04, 32'h0000_01FF, er);
            check($sformatf("push%0d_err", i), 32'(er), 32'(i == 8));
        end
        obi_read(32'h08, rd, er, vl);
        check("full_status", rd, 32'h0000_0802);
        aid_i = 1'b1;
        obi_read(32'h14, rd, er, vl);
        check("bad_rd_err", 32'(er), 32'h1);
        check("bad_rd_data", rd, 32'h0);
        check("bad_rd_rid", 32'(rid_o), 32'h1);
        aid_i = 1'b0;
        obi_write(32'h18, 32'h0000_FFFF, er);
        check("bad_wr_err", 32'(er), 32'h1);
        obi_read(32'h04, rd, er, vl);
        check("txdata_rd_zero", rd, 32'h0);

        // Asynchronous reset in the middle of a shift
        obi_write(32'h00, 32'h0000_0400, er);
        repeat (6) @(negedge clk_i);
        check("pre_rst_cs", 32'(cs_no), 32'h2);
        check("pre_rst_mosi", 32'(mosi_o), 32'h1);
        check("pre_rst_dc", 32'(dc_o), 32'h1);
        rst_i = 1'b1;
        #1;
        check("midrst_cs", 32'(cs_no), 32'h3);
        check("midrst_sck", 32'(sck_o), 32'h0);
        check("midrst_mosi", 32'(mosi_o), 32'h0);
        check("midrst_dc", 32'(dc_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        obi_read(32'h08, rd, er, vl);
        check("midrst_status", rd, 32'h0000_0004);
        obi_read(32'h00, rd, er, vl);
        check("midrst_ctrl", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
